// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StSync,
    StAddr,
    StLen,
    StData,
    StChk,
    StDone
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned TIMEOUT_DEFAULT   = 1024;

  // Counter must be able to hold the full timeout value.
  function automatic int unsigned tmo_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the 256-byte instruction memory; holds the core in reset
// until a frame with a good checksum has been committed.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic              err_sticky
);

  localparam int unsigned TmoW = tmo_width(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              core_hold_q, core_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              err_sticky_q, err_sticky_d;

  logic       hs;
  logic [7:0] chk_sum;
  logic       in_frame;

  assign hs       = in_valid & in_ready_q;
  assign chk_sum  = sum_q + in_data;
  assign in_frame = (state_q == StAddr) || (state_q == StLen) ||
                    (state_q == StData) || (state_q == StChk);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    tmo_d        = tmo_q;
    in_ready_d   = 1'b1;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    core_hold_d  = core_hold_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    err_sticky_d = err_sticky_q;

    if (hs) begin
      unique case (state_q)
        StSync: begin
          if (in_data == SYNC_BYTE) state_d = StAddr;
        end
        StAddr: begin
          addr_d  = ADDR_W'(in_data);
          state_d = StLen;
        end
        StLen: begin
          cnt_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          sum_d   = 8'd0;
          state_d = StData;
        end
        StData: begin
          sum_d     = chk_sum;
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = in_data;
          addr_d    = addr_q + ADDR_W'(1);
          cnt_d     = cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_d = StChk;
        end
        StChk: begin
          if (chk_sum == 8'd0) begin
            done_d       = 1'b1;
            core_hold_d  = 1'b0;
            err_sticky_d = 1'b0;
            state_d      = StDone;
          end else begin
            err_d        = 1'b1;
            err_sticky_d = 1'b1;
            state_d      = StSync;
          end
        end
        StDone: begin
          if (in_data == SYNC_BYTE) begin
            core_hold_d = 1'b1;
            state_d     = StAddr;
          end
        end
        default: state_d = StSync;
      endcase
    end

    // A handshake on the expiry cycle wins over the abort.
    if (!in_frame || hs) begin
      tmo_d = '0;
    end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
      tmo_d        = '0;
      err_d        = 1'b1;
      err_sticky_d = 1'b1;
      core_hold_d  = 1'b1;
      state_d      = StSync;
    end else begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StSync;
      addr_q       <= '0;
      cnt_q        <= '0;
      sum_q        <= '0;
      tmo_q        <= '0;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      core_hold_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      tmo_q        <= tmo_d;
      in_ready_q   <= in_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      core_hold_q  <= core_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign core_hold  = core_hold_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the 256-byte instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and writes each payload byte into instruction memory through a byte write port.
- Holds the core in reset until a frame with a good checksum has been committed.
- Sits between the external download link and the instruction memory write side. The fetch path (pc -> instruction) is unchanged.

Parameters:
- ADDR_W, 8, byte-address width of instruction memory (256 bytes).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1024, idle cycles allowed between bytes inside a frame before abort.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  stream byte valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte; transfer = in_valid & in_ready at rising edge.
- wr_en  output  1  instruction memory byte write strobe.
- wr_addr  output  ADDR_W  byte address to write.
- wr_data  output  8  byte to write.
- core_hold  output  1  high = core held in reset.
- done  output  1  one-cycle pulse on a good frame.
- err  output  1  one-cycle pulse on checksum failure or timeout.
- err_sticky  output  1  set by any err pulse, cleared by reset or by the next good frame.

Behaviour:
- Reset and polarity: clk, with reset synchronous and active-high. While reset is sampled high, every register clears on that edge.
  - Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0, err=0, err_sticky=0, core_hold=1.
  - State returns to SYNC.
  - in_ready rises the first cycle after reset deasserts.
- Frame format: SYNC_BYTE, ADDR (start byte address), LEN (payload count; 0 means 256), LEN payload bytes, CHK.
  - A frame is good when (sum of payload + CHK) mod 256 == 0.
- Byte order: payload bytes go to ascending addresses. The fetch side concatenates mem[pc] as the most significant byte, so a 32-bit instruction is sent MSB first.
- States:
  - SYNC: in_ready=1. A byte equal to SYNC_BYTE -> ADDR; any other byte is consumed and dropped.
  - ADDR: capture addr_ptr, -> LEN.
  - LEN: capture count (0 -> 256), clear the checksum accumulator, -> DATA.
  - DATA: each accepted byte adds to the accumulator and issues a write. Count decrements; after the last byte -> CHK.
  - CHK: add the received byte. If the result is 0: done pulse, core_hold<=0, err_sticky<=0, -> DONE. Otherwise: err pulse, err_sticky<=1, core_hold stays 1, -> SYNC.
  - DONE: in_ready=1. SYNC_BYTE -> core_hold<=1, -> ADDR (re-load); other bytes are dropped.
- Write timing:
  - wr_en/wr_addr/wr_data are registered and asserted exactly one cycle after the payload handshake, for one cycle per byte.
  - Back-to-back bytes give back-to-back writes.
  - addr_ptr increments mod 2^ADDR_W; wrap from 0xFF to 0x00 is legal.
- No rollback: bytes written before a failed checksum or timeout remain in memory. core_hold guarantees the core never runs them.
- Timeout:
  - The counter runs in ADDR, LEN, DATA and CHK and resets on every handshake.
  - Reaching TIMEOUT_CYCLES without a byte: err pulse, err_sticky<=1, -> SYNC, core_hold<=1.
  - No timeout in SYNC or DONE.
- Simultaneous events:
  - A handshake in the same cycle the timeout expires: the handshake wins and no abort occurs.
  - Reset overrides everything.
- Reset mid-frame: abort immediately. Any write registered on that edge is suppressed (wr_en=0 next cycle), -> SYNC, core_hold=1.

Decomposition:
- Package imem_loader_pkg:
  - state enum (SYNC, ADDR, LEN, DATA, CHK, DONE)
  - SYNC_BYTE default
  - timeout counter width, $clog2(TIMEOUT_CYCLES+1)
- Single module. The timeout counter is small enough to stay inline; no sub-module.

Test Plan:
- Good frame: stream A5 00 04 00 02 10 25 C9 -> writes (00,00)(01,02)(02,10)(03,25), each one cycle after its handshake. done pulses one cycle after the C9 handshake, core_hold falls, err_sticky=0.
- Bad checksum: A5 00 04 00 02 10 25 00 -> four writes occur, then err pulses, err_sticky=1, core_hold stays 1, state SYNC. Follow with the good frame -> err_sticky clears.
- Wrap and garbage: 3C 7E A5 FE 04 11 22 33 44 56 -> 3C and 7E are dropped with no writes. Writes go to FE, FF, 00, 01; done pulses.
- LEN=0: A5 00 00, then 256 bytes of 01, then CHK 00 -> exactly 256 writes covering 00..FF; done pulses.
- Timeout: A5 10 02 AA, then in_valid low for 1024 cycles -> err pulses, core_hold=1. Bytes sent afterwards are ignored until A5. Also cover a byte arriving on the expiry cycle -> no err.
- Reset mid-DATA and backpressure: assert reset for one cycle during the DATA handshake -> no wr_en next cycle, core_hold=1, state SYNC. Random in_valid gaps across a good frame -> identical write sequence.
